// File: rtl/vga_fun_pkg.sv
// Shared constants for the VGA pattern generator.
//   - default 640x480@60 timing constants
//   - pattern mode encoding (MODE_BLACK..MODE_WHITE)
//   - colour-bar RGB table, index 0 = leftmost bar
//   - cnt_w(): counter width for a modulus, never below 1 bit
package vga_fun_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [2:0] {
        MODE_BLACK   = 3'd0,
        MODE_XGRAD   = 3'd1,
        MODE_YGRAD   = 3'd2,
        MODE_BARS    = 3'd3,
        MODE_XOR     = 3'd4,
        MODE_ANIM    = 3'd5,
        MODE_CHECKER = 3'd6,
        MODE_WHITE   = 3'd7
    } mode_e;

    // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black.
    // Packed element 0 is the rightmost entry of the concatenation.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_dac_pattern_gen_if.sv
// Video output bundle of the pattern generator.
//   mode/pause      : control into the generator
//   r/g/b, rn/gn/bn : DAC codes and their complements (p/n cells)
//   hsync/vsync     : syncs at their configured polarity
//   hblank/vblank   : outside active columns / lines
//   frame_start     : one-cycle strobe on pixel (0,0)
interface vga_dac_pattern_gen_if #(
    parameter int DAC_BITS = 8
);
    logic [2:0]          mode;
    logic                pause;
    logic [DAC_BITS-1:0] r, g, b;
    logic [DAC_BITS-1:0] rn, gn, bn;
    logic                hsync, vsync;
    logic                hblank, vblank;
    logic                frame_start;

    modport master (
        input  mode, pause,
        output r, g, b, rn, gn, bn, hsync, vsync, hblank, vblank, frame_start
    );

    modport slave (
        output mode, pause,
        input  r, g, b, rn, gn, bn, hsync, vsync, hblank, vblank, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with registered sync/blank decode.
//   clk, rst_n       : pixel clock, async active-low reset
//   h, v             : current counter state (unregistered view for the top)
//   line_end         : h at its last count
//   frame_end        : h and v both at their last count
//   sof              : counters at (0,0)
//   active           : (h,v) inside the visible area
//   hsync..frame_start : registered decode of (h,v), one cycle behind
module vga_timing
    import vga_fun_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    localparam int  H_W = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int  V_W = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           line_end,
    output logic           frame_end,
    output logic           sof,
    output logic           active,
    output logic           hsync,
    output logic           vsync,
    output logic           hblank,
    output logic           vblank,
    output logic           frame_start
);
    localparam logic [H_W-1:0] H_LAST = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_ON  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_OFF = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_ON  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_OFF = V_W'(V_ACTIVE + V_FP + V_SYNC);

    always_comb begin
        line_end  = (h == H_LAST);
        frame_end = line_end && (v == V_LAST);
        sof       = (h == '0) && (v == '0);
        active    = (h < H_ACT) && (v < V_ACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h           <= '0;
            v           <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (line_end) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + V_W'(1);
            end else begin
                h <= h + H_W'(1);
            end
            hblank      <= (h >= H_ACT);
            vblank      <= (v >= V_ACT);
            hsync       <= ((h >= HS_ON) && (h < HS_OFF)) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= ((v >= VS_ON) && (v < VS_OFF)) ? VSYNC_POL : ~VSYNC_POL;
            frame_start <= sof;
        end
    end
endmodule

// File: rtl/vga_dac_pattern_gen.sv
// VGA timing + test-pattern generator feeding differential current-steering DACs.
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : mode/pause in; DAC codes (p and n side), syncs, blanks,
//                frame_start out. All outputs are registered and mutually aligned.
module vga_dac_pattern_gen
    import vga_fun_pkg::*;
#(
    parameter int   DAC_BITS  = 8,
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_dac_pattern_gen_if.master  bus
);
    localparam int H_W   = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_W   = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BX_W  = cnt_w(BAR_W);

    logic [H_W-1:0]      h;
    logic [V_W-1:0]      v;
    logic                line_end, frame_end, sof, active;
    mode_e               mode_q, mode_cur;
    logic [7:0]          fc;
    logic [BX_W-1:0]     bx;
    logic [2:0]          bar;
    logic [7:0]          x, y, pr, pg, pb;
    logic [DAC_BITS-1:0] r_d, g_d, b_d;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .h          (h),
        .v          (v),
        .line_end   (line_end),
        .frame_end  (frame_end),
        .sof        (sof),
        .active     (active),
        .hsync      (bus.hsync),
        .vsync      (bus.vsync),
        .hblank     (bus.hblank),
        .vblank     (bus.vblank),
        .frame_start(bus.frame_start)
    );

    always_comb begin
        x  = 8'(h);
        y  = 8'(v);
        // Pixel (0,0) is rendered in the same cycle mode is latched, so it
        // must already see the incoming mode rather than the stale mode_q.
        mode_cur = sof ? mode_e'(bus.mode) : mode_q;
        pr = 8'h00;
        pg = 8'h00;
        pb = 8'h00;
        case (mode_cur)
            MODE_BLACK:   ;
            MODE_XGRAD:   begin pr = x; pg = x; pb = x; end
            MODE_YGRAD:   begin pr = y; pg = y; pb = y; end
            MODE_BARS: begin
                pr = {8{BAR_RGB[bar][2]}};
                pg = {8{BAR_RGB[bar][1]}};
                pb = {8{BAR_RGB[bar][0]}};
            end
            MODE_XOR:     begin pr = x ^ y; pg = x; pb = y; end
            MODE_ANIM:    begin pr = x + fc; pg = y + fc; pb = fc; end
            MODE_CHECKER: begin pr = {8{x[5] ^ y[5]}}; pg = pr; pb = pr; end
            MODE_WHITE:   begin pr = 8'hFF; pg = 8'hFF; pb = 8'hFF; end
            default:      ;
        endcase
        // Keep the DAC MSBs; blanking forces code 0 (n side dumps full current).
        r_d = active ? pr[7 -: DAC_BITS] : '0;
        g_d = active ? pg[7 -: DAC_BITS] : '0;
        b_d = active ? pb[7 -: DAC_BITS] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_BLACK;
            fc     <= 8'h00;
            bx     <= '0;
            bar    <= 3'd0;
            bus.r  <= '0;
            bus.g  <= '0;
            bus.b  <= '0;
            bus.rn <= '1;
            bus.gn <= '1;
            bus.bn <= '1;
        end else begin
            if (sof) mode_q <= mode_e'(bus.mode);
            if (frame_end && !bus.pause) fc <= fc + 8'd1;
            // Bar index tracks h in lock-step; bx counts pixels inside a bar
            // so no divide by BAR_W is needed.
            if (line_end) begin
                bx  <= '0;
                bar <= 3'd0;
            end else if (bx == BX_W'(BAR_W - 1)) begin
                bx  <= '0;
                bar <= bar + 3'd1;
            end else begin
                bx <= bx + BX_W'(1);
            end
            bus.r  <= r_d;
            bus.g  <= g_d;
            bus.b  <= b_d;
            bus.rn <= ~r_d;
            bus.gn <= ~g_d;
            bus.bn <= ~b_d;
        end
    end
endmodule

// File: tb/tb_vga_dac_pattern_gen.sv
// Bench for vga_dac_pattern_gen: a small raster (80x19) so full frames fit the
// cycle budget, with an 8-bit and a 4-bit DAC instance sharing the stimulus.
// A reference model tracks the pixel position as a linear cycle count and
// derives expected outputs from the raster rules; directed tasks check timing,
// bars, mode latching, pause and reset recovery.
module tb_vga_dac_pattern_gen;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int BW = HA / 8;
    localparam int N = 2 * FRAME + 4;
    localparam bit HPOL = 1'b0, VPOL = 1'b0;
    // Colour per bar as 3-bit rgb: white yellow cyan green magenta red blue black
    localparam int BAR_TBL [8] = '{7, 6, 3, 2, 5, 4, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] mode = 3'd7;
    logic       pause = 1'b0;
    int         errors = 0, checks = 0, nprint = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    vga_dac_pattern_gen_if #(.DAC_BITS(8)) bus8 ();
    vga_dac_pattern_gen_if #(.DAC_BITS(4)) bus4 ();
    assign bus8.mode  = mode;
    assign bus8.pause = pause;
    assign bus4.mode  = mode;
    assign bus4.pause = pause;

    vga_dac_pattern_gen #(
        .DAC_BITS(8), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    vga_dac_pattern_gen #(
        .DAC_BITS(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // ---------------- reference model ----------------
    int         n = 0;
    int         mode_f = 0;
    logic [7:0] fc_m = 8'h00;
    logic [7:0] e_r = 8'h00, e_g = 8'h00, e_b = 8'h00;
    logic       e_hs = ~HPOL, e_vs = ~VPOL, e_hb = 1'b1, e_vb = 1'b1, e_fs = 1'b0;

    function automatic logic [23:0] pix(input int x, input int y, input int md,
                                        input logic [7:0] f);
        logic [7:0] xv, yv, r, g, b;
        int rgb;
        xv = 8'(x);
        yv = 8'(y);
        r = 8'h00; g = 8'h00; b = 8'h00;
        if (x >= HA || y >= VA) return 24'h0;
        case (md)
            1: begin r = xv; g = xv; b = xv; end
            2: begin r = yv; g = yv; b = yv; end
            3: begin
                rgb = BAR_TBL[x / BW];
                r = ((rgb >> 2) & 1) != 0 ? 8'hFF : 8'h00;
                g = ((rgb >> 1) & 1) != 0 ? 8'hFF : 8'h00;
                b = (rgb & 1) != 0 ? 8'hFF : 8'h00;
            end
            4: begin r = xv ^ yv; g = xv; b = yv; end
            5: begin r = xv + f; g = yv + f; b = f; end
            6: begin
                r = (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
                g = r; b = r;
            end
            7: begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
            default: ;
        endcase
        return {r, g, b};
    endfunction

    task automatic model_clear();
        n = 0; mode_f = 0; fc_m = 8'h00;
        e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
        e_hs = ~HPOL; e_vs = ~VPOL; e_hb = 1'b1; e_vb = 1'b1; e_fs = 1'b0;
    endtask

    always @(posedge clk) begin
        int x, y;
        logic [23:0] p;
        if (!rst_n) begin
            model_clear();
        end else begin
            x = n % HT;
            y = n / HT;
            if (x == 0 && y == 0) mode_f = int'(mode);
            p = pix(x, y, mode_f, fc_m);
            {e_r, e_g, e_b} = p;
            e_hs = (x >= HA + HF && x < HA + HF + HS) ? HPOL : ~HPOL;
            e_vs = (y >= VA + VF && y < VA + VF + VS) ? VPOL : ~VPOL;
            e_hb = (x >= HA);
            e_vb = (y >= VA);
            e_fs = (x == 0 && y == 0);
            if (x == HT - 1 && y == VT - 1 && !pause) fc_m = fc_m + 8'd1;
            n = (n + 1) % FRAME;
        end
    end

    // Every-cycle comparison of both DUTs against the model, plus the p/n invariant.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({bus8.r, bus8.g, bus8.b, bus8.rn, bus8.gn, bus8.bn, bus8.hsync, bus8.vsync,
                 bus8.hblank, bus8.vblank, bus8.frame_start} !==
                {e_r, e_g, e_b, ~e_r, ~e_g, ~e_b, e_hs, e_vs, e_hb, e_vb, e_fs}) begin
                errors++;
                if (nprint < 20)
                    $display("FAIL model8 t=%0t got rgb=%h n=%h s=%b%b%b%b%b want rgb=%h s=%b%b%b%b%b",
                             $time, {bus8.r, bus8.g, bus8.b}, {bus8.rn, bus8.gn, bus8.bn},
                             bus8.hsync, bus8.vsync, bus8.hblank, bus8.vblank, bus8.frame_start,
                             {e_r, e_g, e_b}, e_hs, e_vs, e_hb, e_vb, e_fs);
                nprint++;
            end
            checks++;
            if ({bus4.r, bus4.g, bus4.b, bus4.rn, bus4.gn, bus4.bn} !==
                {e_r[7:4], e_g[7:4], e_b[7:4], ~e_r[7:4], ~e_g[7:4], ~e_b[7:4]}) begin
                errors++;
                if (nprint < 20)
                    $display("FAIL model4 t=%0t got %h want %h", $time,
                             {bus4.r, bus4.g, bus4.b}, {e_r[7:4], e_g[7:4], e_b[7:4]});
                nprint++;
            end
            checks++;
            if (({bus8.rn, bus8.gn, bus8.bn} !== ~{bus8.r, bus8.g, bus8.b}) ||
                ({bus4.rn, bus4.gn, bus4.bn} !== ~{bus4.r, bus4.g, bus4.b})) begin
                errors++;
                if (nprint < 20)
                    $display("FAIL complement t=%0t got p=%h n=%h", $time,
                             {bus8.r, bus8.g, bus8.b}, {bus8.rn, bus8.gn, bus8.bn});
                nprint++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_fs(output bit ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < 2 * FRAME + 4) begin
            @(negedge clk);
            i++;
            if (bus8.frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_reset(input int hold);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_clear();
        repeat (hold) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        mode = 3'd7; pause = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        checks++;
        if ({bus8.r, bus8.rn} !== 16'h00FF) begin
            errors++; $display("FAIL reset_codes got r=%h rn=%h want 00/ff", bus8.r, bus8.rn);
        end
        checks++;
        if (bus4.rn !== 4'hF) begin
            errors++; $display("FAIL reset_rn4 got %h want f", bus4.rn);
        end
        checks++;
        if ({bus8.hsync, bus8.vsync, bus8.hblank, bus8.vblank, bus8.frame_start} !== 5'b11110) begin
            errors++;
            $display("FAIL reset_ctrl got %b%b%b%b%b want 11110", bus8.hsync, bus8.vsync,
                     bus8.hblank, bus8.vblank, bus8.frame_start);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus8.frame_start !== 1'b1 || bus8.hblank !== 1'b0) begin
            errors++;
            $display("FAIL first_pixel got fs=%b hblank=%b want 1/0", bus8.frame_start, bus8.hblank);
        end
        checks++;
        if (bus8.r !== 8'hFF) begin
            errors++; $display("FAIL first_pixel_mode got r=%h want ff", bus8.r);
        end
    endtask

    logic [7:0] s_r  [N];
    bit         s_hs [N], s_vs [N], s_hb [N], s_fs [N];

    task automatic test_timing();
        int f0, f1, hf0, hf1, hsf, hsr, r_line, r_frame, vs_low;
        f0 = -1; f1 = -1; hf0 = -1; hf1 = -1; hsf = -1; hsr = -1;
        r_line = -1; r_frame = -1; vs_low = -1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            s_r[i] = bus8.r; s_hs[i] = bus8.hsync; s_vs[i] = bus8.vsync;
            s_hb[i] = bus8.hblank; s_fs[i] = bus8.frame_start;
        end
        for (int i = 1; i < N; i++) begin
            if (s_fs[i]) begin
                if (f0 < 0) f0 = i; else if (f1 < 0) f1 = i;
            end
            if (s_hb[i-1] && !s_hb[i]) begin
                if (hf0 < 0) hf0 = i; else if (hf1 < 0) hf1 = i;
            end
            if (hf0 >= 0 && hsf < 0 && s_hs[i-1] && !s_hs[i]) hsf = i;
            if (hsf >= 0 && hsr < 0 && i > hsf && !s_hs[i-1] && s_hs[i]) hsr = i;
        end
        if (f0 >= 0 && f0 + FRAME <= N) begin
            r_line = 0; r_frame = 0; vs_low = 0;
            for (int i = f0; i < f0 + FRAME; i++) begin
                if (s_r[i] == 8'hFF) begin
                    r_frame++;
                    if (i < f0 + HT) r_line++;
                end
                if (!s_vs[i]) vs_low++;
            end
        end
        checks++;
        if (hf1 - hf0 != HT) begin errors++; $display("FAIL line_period got %0d want %0d", hf1 - hf0, HT); end
        checks++;
        if (hsf - hf0 != HA + HF) begin errors++; $display("FAIL hsync_start got %0d want %0d", hsf - hf0, HA + HF); end
        checks++;
        if (hsr - hsf != HS) begin errors++; $display("FAIL hsync_width got %0d want %0d", hsr - hsf, HS); end
        checks++;
        if (r_line != HA) begin errors++; $display("FAIL white_line got %0d want %0d", r_line, HA); end
        checks++;
        if (r_frame != HA * VA) begin errors++; $display("FAIL white_frame got %0d want %0d", r_frame, HA * VA); end
        checks++;
        if (f1 - f0 != FRAME) begin errors++; $display("FAIL frame_period got %0d want %0d", f1 - f0, FRAME); end
        checks++;
        if (vs_low != VS * HT) begin errors++; $display("FAIL vsync_width got %0d want %0d", vs_low, VS * HT); end
    endtask

    task automatic test_bars();
        bit ok;
        @(negedge clk);
        mode = 3'd3;
        wait_fs(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bars_timeout got no frame_start want one"); end
        checks++;
        if ({bus8.r, bus8.g, bus8.b} !== 24'hFFFFFF || {bus4.r, bus4.g, bus4.b} !== 12'hFFF) begin
            errors++; $display("FAIL bar_white got %h want ffffff", {bus8.r, bus8.g, bus8.b});
        end
        repeat (BW) @(negedge clk);
        checks++;
        if ({bus8.r, bus8.g, bus8.b} !== 24'hFFFF00) begin
            errors++; $display("FAIL bar_yellow got %h want ffff00", {bus8.r, bus8.g, bus8.b});
        end
        repeat (BW) @(negedge clk);
        checks++;
        if ({bus8.r, bus8.g, bus8.b} !== 24'h00FFFF) begin
            errors++; $display("FAIL bar_cyan got %h want 00ffff", {bus8.r, bus8.g, bus8.b});
        end
        repeat (5 * BW) @(negedge clk);
        checks++;
        if ({bus8.r, bus8.g, bus8.b} !== 24'h000000) begin
            errors++; $display("FAIL bar_black got %h want 000000", {bus8.r, bus8.g, bus8.b});
        end
        repeat (BW) @(negedge clk);
        checks++;
        if ({bus8.r, bus8.g, bus8.b} !== 24'h0 || {bus8.rn, bus8.gn, bus8.bn} !== 24'hFFFFFF
            || bus8.hblank !== 1'b1) begin
            errors++;
            $display("FAIL bar_blank got p=%h n=%h hb=%b want 000000/ffffff/1",
                     {bus8.r, bus8.g, bus8.b}, {bus8.rn, bus8.gn, bus8.bn}, bus8.hblank);
        end
    endtask

    task automatic test_mode_switch();
        bit ok;
        int bad;
        @(negedge clk);
        mode = 3'd1;
        wait_fs(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL switch_timeout got no frame_start want one"); end
        repeat (40) @(negedge clk);
        checks++;
        if (bus8.r !== 8'd40 || bus4.r !== 4'd2) begin
            errors++; $display("FAIL xgrad got r8=%h r4=%h want 28/2", bus8.r, bus4.r);
        end
        repeat (6 * HT - 40) @(negedge clk);
        mode = 3'd2;
        repeat (2 * HT + 10) @(negedge clk);
        checks++;
        if (bus8.r !== 8'd10 || bus8.g !== 8'd10) begin
            errors++; $display("FAIL midframe_hold got r=%h g=%h want 0a", bus8.r, bus8.g);
        end
        wait_fs(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL switch_timeout2 got no frame_start want one"); end
        repeat (5 * HT) @(negedge clk);
        bad = 0;
        for (int i = 0; i < HA; i++) begin
            if ({bus8.r, bus8.g, bus8.b} !== 24'h050505) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ygrad_line5 got %0d bad pixels want 0", bad); end
    endtask

    task automatic test_pause();
        bit ok;
        mode = 3'd5;
        pause = 1'b1;
        pulse_reset(3);
        for (int f = 0; f < 3; f++) begin
            wait_fs(ok);
            checks++;
            if (!ok || bus8.b !== 8'h00) begin
                errors++; $display("FAIL paused_b frame %0d got %h want 00", f, bus8.b);
            end
            repeat (20) @(negedge clk);
            checks++;
            if (bus8.r !== 8'd20) begin
                errors++; $display("FAIL paused_r frame %0d got %h want 14", f, bus8.r);
            end
        end
        pause = 1'b0;
        wait_fs(ok);
        checks++;
        if (!ok || bus8.b !== 8'h01) begin
            errors++; $display("FAIL resumed_b got %h want 01", bus8.b);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (bus8.r !== 8'd21 || bus8.g !== 8'h01 || bus4.r !== 4'h1) begin
            errors++;
            $display("FAIL resumed_rg got r=%h g=%h r4=%h want 15/01/1", bus8.r, bus8.g, bus4.r);
        end
    endtask

    task automatic test_random();
        int  total;
        bit  did_rst;
        int  len;
        total = 0;
        did_rst = 1'b0;
        while (total < 10 * FRAME) begin
            len = $urandom_range(100, 400);
            repeat (len) @(negedge clk);
            total += len;
            mode  = 3'($urandom_range(0, 7));
            pause = 1'($urandom_range(0, 1));
            if (!did_rst && total > 4 * FRAME) begin
                pulse_reset($urandom_range(1, 4));
                @(negedge clk);
                checks++;
                if ({bus8.frame_start, bus8.hblank, bus8.vblank, bus8.hsync} !== 4'b1001) begin
                    errors++;
                    $display("FAIL restart got fs/hb/vb/hs=%b%b%b%b want 1001",
                             bus8.frame_start, bus8.hblank, bus8.vblank, bus8.hsync);
                end
                did_rst = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_mode_switch();
        test_pause();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
